nv_nvdla_nocif_dram_wr_cpl: RTL and testbench

Write-completion tracker for the NOCIF DRAM write path. It sits beside the write arbiter and AXI write engine, between the AXI AW/B channels and the DMA write clients. It counts outstanding AXI write bursts, globally and per client, and throttles the arbiter against the programmed write outstanding limit. It also consumes B-channel responses and returns one-cycle `mcif2client<i>_wr_rsp_complete` pulses to the originating client.

---
 rtl/nv_nvdla_nocif_pkg.sv | 15 +
 rtl/nv_nvdla_nocif_os_ctr.sv | 41 ++++
 rtl/nv_nvdla_nocif_dram_wr_cpl.sv | 128 ++++++++++++
 tb/tb_nv_nvdla_nocif_dram_wr_cpl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_nocif_pkg.sv
// Shared constants and helpers for the NOCIF DRAM write path.
// Client indices travel in the low nibble of the AXI id.
package nv_nvdla_nocif_pkg;

    localparam int NOCIF_CLIENT_IDX_W   = 4;
    localparam int NOCIF_OS_CNT_W       = 9;
    localparam int NOCIF_MAX_WR_CLIENTS = 5;
    localparam int NOCIF_OS_CNT_MAX     = 256;

    function automatic logic nocif_idx_ok(input logic [NOCIF_CLIENT_IDX_W-1:0] idx,
                                          input int num_clients);
        return int'(idx) < num_clients;
    endfunction

endpackage

// File: rtl/nv_nvdla_nocif_os_ctr.sv
// Saturating up/down outstanding counter: holds at MAX_VAL and at zero,
// flagging the blocked increment (ovf) or decrement (unf) for that cycle.
module nv_nvdla_nocif_os_ctr #(
    parameter int CNT_W   = 9,
    parameter int MAX_VAL = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) ovf = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) unf = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nv_nvdla_nocif_dram_wr_cpl.sv
// Write-completion tracker: counts outstanding AXI write bursts globally and per
// client, throttles the arbiter, and turns B responses into client completion pulses.
module nv_nvdla_nocif_dram_wr_cpl
    import nv_nvdla_nocif_pkg::*;
#(
    parameter int NUM_CLIENTS = NOCIF_MAX_WR_CLIENTS,
    parameter int CNT_W       = NOCIF_OS_CNT_W
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [7:0]             reg2dp_wr_os_cnt,
    input  logic                   aw_fire,
    input  logic [7:0]             aw_id,
    input  logic                   noc2mcif_axi_b_bvalid,
    output logic                   noc2mcif_axi_b_bready,
    input  logic [7:0]             noc2mcif_axi_b_bid,
    output logic                   wr_os_stall,
    output logic [NUM_CLIENTS-1:0] mcif2client_wr_rsp_complete,
    output logic                   wr_cpl_err,
    output logic                   wr_cpl_idle
);

    localparam int IW = NOCIF_CLIENT_IDX_W;

    logic [IW-1:0]          aw_idx;
    logic [IW-1:0]          b_idx;
    logic                   aw_idx_ok;
    logic                   b_idx_ok;
    logic                   b_cl_nz;
    logic                   b_acc;
    logic                   aw_ok;
    logic                   b_ok;
    logic [NUM_CLIENTS-1:0] cl_inc;
    logic [NUM_CLIENTS-1:0] cl_dec;
    logic [NUM_CLIENTS-1:0] cl_ovf;
    logic [NUM_CLIENTS-1:0] cl_unf;
    logic [CNT_W-1:0]       cl_cnt [NUM_CLIENTS];
    logic [CNT_W-1:0]       os_cnt;
    logic                   os_ovf;
    logic                   os_unf;
    logic [CNT_W-1:0]       os_limit;

    logic                   bready_q, bready_d;
    logic                   err_q, err_d;
    logic [NUM_CLIENTS-1:0] cpl_q, cpl_d;

    logic                   unused_id_hi;
    assign unused_id_hi = ^{aw_id[7:IW], noc2mcif_axi_b_bid[7:IW]};

    // A B response is honoured only for a known client that still has a burst in flight.
    always_comb begin
        aw_idx    = aw_id[IW-1:0];
        b_idx     = noc2mcif_axi_b_bid[IW-1:0];
        aw_idx_ok = nocif_idx_ok(aw_idx, NUM_CLIENTS);
        b_idx_ok  = nocif_idx_ok(b_idx, NUM_CLIENTS);
        b_cl_nz   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (b_idx == IW'(i)) b_cl_nz = (cl_cnt[i] != '0);
        end
        b_acc = noc2mcif_axi_b_bvalid & bready_q;
        aw_ok = aw_fire & aw_idx_ok;
        b_ok  = b_acc & b_idx_ok & b_cl_nz;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cl_inc[i] = aw_ok & (aw_idx == IW'(i));
            cl_dec[i] = b_ok & (b_idx == IW'(i));
        end
        cpl_d    = cl_dec;
        bready_d = 1'b1;
    end

    always_comb begin
        err_d = err_q
              | (aw_fire & ~aw_idx_ok)
              | (b_acc & ~b_ok)
              | os_ovf | os_unf
              | (|cl_ovf) | (|cl_unf);
    end

    nv_nvdla_nocif_os_ctr #(
        .CNT_W   (CNT_W),
        .MAX_VAL (NOCIF_OS_CNT_MAX)
    ) u_os_ctr (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .inc   (aw_ok),
        .dec   (b_ok),
        .cnt   (os_cnt),
        .ovf   (os_ovf),
        .unf   (os_unf)
    );

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cl_ctr
        nv_nvdla_nocif_os_ctr #(
            .CNT_W   (CNT_W),
            .MAX_VAL (NOCIF_OS_CNT_MAX)
        ) u_cl_ctr (
            .clk   (nvdla_core_clk),
            .rst_n (nvdla_core_rstn),
            .inc   (cl_inc[gi]),
            .dec   (cl_dec[gi]),
            .cnt   (cl_cnt[gi]),
            .ovf   (cl_ovf[gi]),
            .unf   (cl_unf[gi])
        );
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            bready_q <= 1'b0;
            cpl_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            bready_q <= bready_d;
            cpl_q    <= cpl_d;
            err_q    <= err_d;
        end
    end

    // Limit is value+1, so the compare is widened before the add to reach 256.
    assign os_limit    = CNT_W'(reg2dp_wr_os_cnt) + CNT_W'(1);
    assign wr_os_stall = (os_cnt >= os_limit);

    assign noc2mcif_axi_b_bready       = bready_q;
    assign mcif2client_wr_rsp_complete = cpl_q;
    assign wr_cpl_err                  = err_q;
    assign wr_cpl_idle                 = (os_cnt == '0) && (cpl_q == '0);

endmodule

// File: tb/tb_nv_nvdla_nocif_dram_wr_cpl.sv
// Bench for the write-completion tracker: directed vector table, reset and
// saturation sequences, and randomized traffic against a behavioural model.
module tb_nv_nvdla_nocif_dram_wr_cpl;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rstn;
    logic [7:0]   lim;
    logic         aw_fire;
    logic [7:0]   aw_id;
    logic         bvalid;
    logic [7:0]   bid;
    logic         bready;
    logic         stall;
    logic [N-1:0] cpl;
    logic         err;
    logic         idle;

    always #5 clk = ~clk;

    nv_nvdla_nocif_dram_wr_cpl #(.NUM_CLIENTS(N), .CNT_W(9)) dut (
        .nvdla_core_clk              (clk),
        .nvdla_core_rstn             (rstn),
        .reg2dp_wr_os_cnt            (lim),
        .aw_fire                     (aw_fire),
        .aw_id                       (aw_id),
        .noc2mcif_axi_b_bvalid       (bvalid),
        .noc2mcif_axi_b_bready       (bready),
        .noc2mcif_axi_b_bid          (bid),
        .wr_os_stall                 (stall),
        .mcif2client_wr_rsp_complete (cpl),
        .wr_cpl_err                  (err),
        .wr_cpl_idle                 (idle)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state: plain integers per the counting rules.
    int m_os;
    int m_cl [16];
    bit m_err;
    int m_cpl;
    bit m_bready;

    typedef struct {
        bit           af;
        logic [7:0]   aid;
        bit           bv;
        logic [7:0]   b;
        logic [7:0]   l;
        logic [N-1:0] e_cpl;
        bit           e_stall;
        bit           e_err;
        bit           e_idle;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_os = 0;
        for (int i = 0; i < 16; i++) m_cl[i] = 0;
        m_err    = 1'b0;
        m_cpl    = -1;
        m_bready = 1'b0;
    endtask

    task automatic model_step(input bit af, input logic [7:0] aid, input bit bv, input logic [7:0] b);
        int  ai, bi, delta;
        bit  bacc, awok, bok;
        ai   = int'(aid[3:0]);
        bi   = int'(b[3:0]);
        bacc = bv && m_bready;
        awok = af && (ai < N);
        bok  = bacc && (bi < N) && (m_cl[bi] > 0);
        if (af && !awok) m_err = 1'b1;
        if (bacc && !bok) m_err = 1'b1;
        delta = int'(awok) - int'(bok);
        if (delta == 1) begin
            if (m_os == 256) m_err = 1'b1;
            else m_os++;
        end else if (delta == -1) begin
            if (m_os == 0) m_err = 1'b1;
            else m_os--;
        end
        if (!(awok && bok && ai == bi)) begin
            if (awok) begin
                if (m_cl[ai] == 256) m_err = 1'b1;
                else m_cl[ai]++;
            end
            if (bok) m_cl[bi]--;
        end
        m_cpl    = bok ? bi : -1;
        m_bready = 1'b1;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] e_cpl;
        e_cpl = (m_cpl >= 0) ? (N'(1) << m_cpl) : '0;
        chk({tag, "_cpl"},    32'(cpl),    32'(e_cpl));
        chk({tag, "_stall"},  32'(stall),  32'(m_os >= int'(lim) + 1));
        chk({tag, "_err"},    32'(err),    32'(m_err));
        chk({tag, "_idle"},   32'(idle),   32'(m_os == 0 && m_cpl < 0));
        chk({tag, "_bready"}, 32'(bready), 32'(m_bready));
    endtask

    task automatic cyc(input bit af, input logic [7:0] aid, input bit bv, input logic [7:0] b,
                       input string tag);
        aw_fire = af;
        aw_id   = aid;
        bvalid  = bv;
        bid     = b;
        @(posedge clk);
        model_step(af, aid, bv, b);
        #1;
        aw_fire = 1'b0;
        bvalid  = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        aw_fire = 1'b0;
        bvalid  = 1'b0;
        aw_id   = '0;
        bid     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1 m_bready = 1'b1;
    endtask

    task automatic add(input bit af, input logic [7:0] aid, input bit bv, input logic [7:0] b,
                       input logic [7:0] l, input logic [N-1:0] ec, input bit es, input bit ee,
                       input bit ei);
        vec_t v;
        v.af = af; v.aid = aid; v.bv = bv; v.b = b; v.l = l;
        v.e_cpl = ec; v.e_stall = es; v.e_err = ee; v.e_idle = ei;
        tbl.push_back(v);
    endtask

    initial begin
        lim = 8'd3;
        // Single burst, simultaneous AW/B, back-to-back B
        add(1, 8'h02, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(0, 8'h00, 1, 8'h02, 3, 5'b00100, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 0, 1);
        add(1, 8'h01, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(1, 8'h01, 1, 8'h01, 3, 5'b00010, 0, 0, 0);
        add(0, 8'h00, 1, 8'h01, 3, 5'b00010, 0, 0, 0);
        add(1, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(1, 8'h04, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(1, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(0, 8'h00, 1, 8'h00, 3, 5'b00001, 0, 0, 0);
        add(0, 8'h00, 1, 8'h04, 3, 5'b10000, 0, 0, 0);
        add(0, 8'h00, 1, 8'h00, 3, 5'b00001, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 0, 1);
        // Throttle at limit 3 (max 4 outstanding)
        add(1, 8'h03, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(1, 8'h03, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(1, 8'h03, 0, 8'h00, 3, 5'b00000, 0, 0, 0);
        add(1, 8'h03, 0, 8'h00, 3, 5'b00000, 1, 0, 0);
        add(0, 8'h00, 0, 8'h00, 3, 5'b00000, 1, 0, 0);
        add(0, 8'h00, 1, 8'h03, 3, 5'b01000, 0, 0, 0);
        add(1, 8'h03, 0, 8'h00, 3, 5'b00000, 1, 0, 0);
        add(0, 8'h00, 1, 8'h03, 3, 5'b01000, 0, 0, 0);
        add(0, 8'h00, 1, 8'h03, 3, 5'b01000, 0, 0, 0);
        add(0, 8'h00, 1, 8'h03, 3, 5'b01000, 0, 0, 0);
        add(0, 8'h00, 1, 8'h03, 3, 5'b01000, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 0, 1);
        // Protocol errors
        add(0, 8'h00, 1, 8'h07, 3, 5'b00000, 0, 1, 1);
        add(0, 8'h00, 1, 8'h03, 3, 5'b00000, 0, 1, 1);
        add(1, 8'h0F, 0, 8'h00, 3, 5'b00000, 0, 1, 1);
        add(0, 8'h00, 0, 8'h00, 3, 5'b00000, 0, 1, 1);

        do_reset();
        chk("post_rst_bready", 32'(bready), 32'd1);
        chk("post_rst_idle",   32'(idle),   32'd1);
        chk("post_rst_err",    32'(err),    32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 21) begin
                lim = 8'd7;
                #1 chk("lim_raise_stall", 32'(stall), 32'd0);
                lim = 8'd3;
                #1 chk("lim_restore_stall", 32'(stall), 32'd1);
            end
            lim     = tbl[i].l;
            aw_fire = tbl[i].af;
            aw_id   = tbl[i].aid;
            bvalid  = tbl[i].bv;
            bid     = tbl[i].b;
            @(posedge clk);
            #1;
            aw_fire = 1'b0;
            bvalid  = 1'b0;
            chk($sformatf("tbl%0d_cpl", i),   32'(cpl),   32'(tbl[i].e_cpl));
            chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_err", i),   32'(err),   32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_idle", i),  32'(idle),  32'(tbl[i].e_idle));
        end

        // Reset mid-traffic with 3 bursts outstanding and a pulse showing
        do_reset();
        lim = 8'd7;
        cyc(1, 8'h00, 0, 8'h00, "rs_aw0");
        cyc(1, 8'h01, 0, 8'h00, "rs_aw1");
        cyc(1, 8'h02, 0, 8'h00, "rs_aw2");
        cyc(1, 8'h03, 0, 8'h00, "rs_aw3");
        cyc(0, 8'h00, 1, 8'h03, "rs_b3");
        rstn = 1'b0;
        model_reset();
        #1 check_model("rs_async");
        @(posedge clk);
        #1 check_model("rs_held");
        rstn = 1'b1;
        #1 check_model("rs_release");
        @(posedge clk);
        #1 m_bready = 1'b1;
        check_model("rs_bready");
        cyc(0, 8'h00, 1, 8'h01, "rs_stale_b");

        // Global and per-client counters saturate at 256
        do_reset();
        lim = 8'd255;
        for (int i = 0; i < 257; i++) cyc(1, 8'h00, 0, 8'h00, "sat_aw");
        for (int i = 0; i < 256; i++) cyc(0, 8'h00, 1, 8'h00, "sat_b");
        cyc(0, 8'h00, 0, 8'h00, "sat_idle");
        cyc(0, 8'h00, 1, 8'h00, "sat_extra_b");

        // Randomized traffic: clean phase, then with invalid ids mixed in
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            lim = 8'($urandom_range(0, 7));
            for (int c = 0; c < 1500; c++) begin
                bit          af, bv, found;
                logic [7:0]  aid, b;
                int          k;
                if ($urandom_range(0, 31) == 0) lim = 8'($urandom_range(0, 7));
                af = ($urandom_range(0, 1) == 1) &&
                     ((m_os < int'(lim) + 1) || ($urandom_range(0, 15) == 0));
                aid = {4'($urandom_range(0, 15)), 4'($urandom_range(0, N - 1))};
                if (ph == 1 && $urandom_range(0, 15) == 0) aid[3:0] = 4'($urandom_range(N, 15));
                k = $urandom_range(0, N - 1);
                found = 1'b0;
                b = {4'($urandom_range(0, 15)), 4'(k)};
                for (int t = 0; t < N; t++) begin
                    if (!found && m_cl[(k + t) % N] > 0) begin
                        found  = 1'b1;
                        b[3:0] = 4'((k + t) % N);
                    end
                end
                bv = found && ($urandom_range(0, 1) == 1);
                if (ph == 1 && $urandom_range(0, 15) == 0) begin
                    bv = 1'b1;
                    b  = 8'($urandom_range(0, 255));
                end
                cyc(af, aid, bv, b, $sformatf("rnd%0d", ph));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
